// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// WIDTH-bit universal register with clock enable. It can hold, parallel load,
// shift left/right (logical), rotate left/right, arithmetic shift right, and
// clear. A modulo-WIDTH counter tracks shift operations since the last
// load/clear/completed pass. A registered one-cycle pulse marks the edge that
// completes the WIDTH-th shift, so the block can act as a serializer or
// deserializer stage.
//
// Parameters:
//   WIDTH    register width, 2..32
//   CW       shift-counter width, derived from WIDTH
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (wins over en)
//   en       clock enable; 0 holds q and cnt and drops pass
//   mode     operation select (see mode_e)
//   d        parallel load data
//   sin_lsb  serial bit entering q[0] on shift left
//   sin_msb  serial bit entering q[WIDTH-1] on logical shift right
//   q        register contents
//   sout_msb q[WIDTH-1]
//   sout_lsb q[0]
//   cnt      shift operations since last load/clear/pass, modulo WIDTH
//   pass     one-cycle pulse: WIDTH shift operations completed
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    cnt,
  output logic             pass
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q,    q_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             pass_q, pass_d;
  logic             is_shift;

  // Next-state for the enabled case; en and reset are applied in the flop.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    q_d      = q_q;
    cnt_d    = cnt_q;
    pass_d   = 1'b0;
    is_shift = 1'b0;

    case (mode_e'(mode))
      MODE_HOLD:  ;
      MODE_LOAD: begin
        q_d   = d;
        cnt_d = '0;
      end
      MODE_SHL: begin
        q_d      = {q_q[WIDTH-2:0], sin_lsb};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_d      = {sin_msb, q_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        q_d      = {q_q[0], q_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_CLEAR: begin
        q_d   = '0;
        cnt_d = '0;
      end
    endcase

    // Every shift op counts regardless of direction. Compare against
    // WIDTH-1 explicitly so non-power-of-two widths wrap correctly.
    if (is_shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        pass_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (en) begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
    end else begin
      // Disabled: state holds, but the pulse must still be only one cycle.
      pass_q <= 1'b0;
    end
  end

  assign q        = q_q;
  assign cnt      = cnt_q;
  assign pass     = pass_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];

endmodule
